// File: rtl/output_writeback_bank_pkg.sv
// Shared types and default sizes for the output writeback bank.
// Holds the FSM state enum and the default geometry of the OFMAP write path.
package output_writeback_bank_pkg;

    localparam int OUT_WIDTH     = 16;
    localparam int OFMAP_DEPTH_W = 12;
    localparam int OB_BANK_W     = 8;

    typedef enum logic [1:0] {
        OB_IDLE    = 2'b00,
        OB_CAPTURE = 2'b01,
        OB_DRAIN   = 2'b10,
        OB_FINISH  = 2'b11
    } ob_state_t;

    // Column results are accepted only while a layer is being collected or drained.
    function automatic logic ob_is_active(input ob_state_t state);
        return (state == OB_CAPTURE) || (state == OB_DRAIN);
    endfunction

endpackage

// File: rtl/output_writeback_bank_if.sv
// Result-column inputs and OFMAP SRAM write port of the output writeback bank.
// The master drives the column strobes and observes the writes; the slave is the bank.
interface output_writeback_bank_if
    import output_writeback_bank_pkg::*;
#(
    parameter int BANK_WIDTH = OB_BANK_W,
    parameter int DATA_W     = OUT_WIDTH,
    parameter int ADDR_W     = OFMAP_DEPTH_W
) ();

    logic [BANK_WIDTH-1:0]             col_valid;
    logic [BANK_WIDTH-1:0][DATA_W-1:0] col_data;
    logic                              sram_wr_en;
    logic [ADDR_W-1:0]                 sram_addr;
    logic [DATA_W-1:0]                 sram_data;

    modport master (
        output col_valid,
        output col_data,
        input  sram_wr_en,
        input  sram_addr,
        input  sram_data
    );

    modport slave (
        input  col_valid,
        input  col_data,
        output sram_wr_en,
        output sram_addr,
        output sram_data
    );

endinterface

// File: rtl/output_writeback_bank_ob_column_slot.sv
// One capture slot: a result register plus its occupancy flag.
// A load in the same cycle as the drain clear wins, so a new row can overlap the drain.
module output_writeback_bank_ob_column_slot #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_sync_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              occ_o
);

    logic [DATA_W-1:0] data_r;
    logic              occ_r;

    // Slot register: flush beats load, load beats drain clear.
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            data_r <= {DATA_W{1'b0}};
            occ_r  <= 1'b0;
        end else if (flush_i) begin
            occ_r  <= 1'b0;
        end else if (load_i) begin
            data_r <= data_i;
            occ_r  <= 1'b1;
        end else if (clear_i) begin
            occ_r  <= 1'b0;
        end
    end

    assign data_o = data_r;
    assign occ_o  = occ_r;

endmodule

// File: rtl/output_writeback_bank.sv
// Output writeback bank: captures a skewed row of column results, then writes it to OFMAP SRAM.
// Build option OB_RELU_EN clamps negative words to zero on the way out.
module output_writeback_bank
    import output_writeback_bank_pkg::*;
#(
    parameter int BANK_WIDTH = OB_BANK_W,
    parameter int DATA_W     = OUT_WIDTH,
    parameter int ADDR_W     = OFMAP_DEPTH_W
) (
    input  logic              clk_i,
    input  logic              rst_sync_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [31:0]       cfg_out_w_i,
    input  logic [31:0]       cfg_out_h_i,
    input  logic [ADDR_W-1:0] cfg_base_addr_i,
    output_writeback_bank_if.slave ob_bus,
    output logic              ob_ready_o,
    output logic              row_done_o,
    output logic              done_o,
    output logic              err_overflow_o
);

    localparam int PTR_W = (BANK_WIDTH > 1) ? $clog2(BANK_WIDTH) : 1;
    localparam int CNT_W = $clog2(BANK_WIDTH + 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    ob_state_t         state_r;
    logic [CNT_W-1:0]  occ_cnt_r;
    logic [CNT_W-1:0]  add_cnt_s;
    logic [CNT_W-1:0]  sub_cnt_s;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [31:0]       row_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] sram_addr_r;
    logic [DATA_W-1:0] sram_data_r;
    logic [DATA_W-1:0] slot_word_s;
    logic [DATA_W-1:0] drain_word_s;
    logic              wr_en_r;
    logic              last_wr_r;
    logic              row_done_r;
    logic              done_r;
    logic              ready_r;
    logic              err_r;

    logic [BANK_WIDTH-1:0] occ_s;
    logic [BANK_WIDTH-1:0] load_s;
    logic [BANK_WIDTH-1:0] drop_s;
    logic [BANK_WIDTH-1:0] drain_s;
    logic [DATA_W-1:0]     slot_data_s [BANK_WIDTH];

    logic capture_en_s;
    logic drain_en_s;
    logic flush_s;
    logic last_col_s;
    logic occ_full_s;
    logic more_rows_s;

    // Cycle-level enables and row/layer boundary decodes.
    always_comb begin
        capture_en_s = ob_is_active(state_r) && !abort_i;
        drain_en_s   = (state_r == OB_DRAIN) && !abort_i;
        flush_s      = abort_i || ((state_r == OB_IDLE) && start_i);
        last_col_s   = ({{(32-PTR_W){1'b0}}, rd_ptr_r} == (cfg_out_w_i - 32'd1));
        occ_full_s   = ({{(32-CNT_W){1'b0}}, occ_cnt_r} == cfg_out_w_i);
        more_rows_s  = ((row_cnt_r + 32'd1) < cfg_out_h_i);
    end

    generate
        for (genvar j = 0; j < BANK_WIDTH; j++) begin : g_slot
            logic in_row_s;
            logic hit_s;

            assign in_row_s   = (32'(j) < cfg_out_w_i);
            assign hit_s      = capture_en_s && ob_bus.col_valid[j] && in_row_s;
            assign drain_s[j] = drain_en_s && (rd_ptr_r == PTR_W'(j));
            // An occupied slot may only be reloaded in the cycle it is being drained.
            assign load_s[j]  = hit_s && (!occ_s[j] || drain_s[j]);
            assign drop_s[j]  = hit_s && occ_s[j] && !drain_s[j];

            output_writeback_bank_ob_column_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk_i      (clk_i),
                .rst_sync_i (rst_sync_i),
                .flush_i    (flush_s),
                .load_i     (load_s[j]),
                .clear_i    (drain_s[j]),
                .data_i     (ob_bus.col_data[j]),
                .data_o     (slot_data_s[j]),
                .occ_o      (occ_s[j])
            );
        end
    endgenerate

    // Occupancy delta for this cycle: accepted captures in, at most one drained slot out.
    always_comb begin
        add_cnt_s = {CNT_W{1'b0}};
        for (int k = 0; k < BANK_WIDTH; k++) begin
            add_cnt_s = add_cnt_s + {{(CNT_W-1){1'b0}}, load_s[k]};
        end
        sub_cnt_s = {{(CNT_W-1){1'b0}}, drain_en_s};
    end

    // Word presented to the SRAM for the column under the read pointer.
    always_comb begin
        slot_word_s = slot_data_s[rd_ptr_r];
`ifdef OB_RELU_EN
        if (slot_word_s[DATA_W-1]) begin
            drain_word_s = {DATA_W{1'b0}};
        end else begin
            drain_word_s = slot_word_s;
        end
`else
        drain_word_s = slot_word_s;
`endif
    end

    // Control FSM with counters, address generation and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            state_r     <= OB_IDLE;
            occ_cnt_r   <= {CNT_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            row_cnt_r   <= 32'd0;
            addr_r      <= {ADDR_W{1'b0}};
            sram_addr_r <= {ADDR_W{1'b0}};
            sram_data_r <= {DATA_W{1'b0}};
            wr_en_r     <= 1'b0;
            last_wr_r   <= 1'b0;
            row_done_r  <= 1'b0;
            done_r      <= 1'b0;
            ready_r     <= 1'b0;
            err_r       <= 1'b0;
        end else if (abort_i) begin
            state_r    <= OB_IDLE;
            occ_cnt_r  <= {CNT_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_en_r    <= 1'b0;
            last_wr_r  <= 1'b0;
            row_done_r <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            wr_en_r    <= 1'b0;
            last_wr_r  <= 1'b0;
            done_r     <= 1'b0;
            row_done_r <= last_wr_r;
            occ_cnt_r  <= occ_cnt_r + add_cnt_s - sub_cnt_s;
            if (|drop_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                OB_IDLE: begin
                    if (start_i) begin
                        state_r   <= OB_CAPTURE;
                        addr_r    <= cfg_base_addr_i;
                        row_cnt_r <= 32'd0;
                        rd_ptr_r  <= {PTR_W{1'b0}};
                        occ_cnt_r <= {CNT_W{1'b0}};
                        err_r     <= 1'b0;
                        ready_r   <= 1'b1;
                    end else begin
                        ready_r   <= 1'b0;
                    end
                end
                OB_CAPTURE: begin
                    ready_r <= 1'b1;
                    if (occ_full_s) begin
                        state_r  <= OB_DRAIN;
                        rd_ptr_r <= {PTR_W{1'b0}};
                    end
                end
                OB_DRAIN: begin
                    wr_en_r     <= 1'b1;
                    sram_addr_r <= addr_r;
                    sram_data_r <= drain_word_s;
                    addr_r      <= addr_r + ADDR_ONE;
                    if (last_col_s) begin
                        last_wr_r <= 1'b1;
                        rd_ptr_r  <= {PTR_W{1'b0}};
                        if (more_rows_s) begin
                            state_r   <= OB_CAPTURE;
                            row_cnt_r <= row_cnt_r + 32'd1;
                            ready_r   <= 1'b1;
                        end else begin
                            state_r   <= OB_FINISH;
                            done_r    <= 1'b1;
                            ready_r   <= 1'b0;
                        end
                    end else begin
                        rd_ptr_r <= rd_ptr_r + PTR_ONE;
                        ready_r  <= 1'b1;
                    end
                end
                OB_FINISH: begin
                    state_r <= OB_IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= OB_IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign ob_bus.sram_wr_en = wr_en_r;
    assign ob_bus.sram_addr  = sram_addr_r;
    assign ob_bus.sram_data  = sram_data_r;
    assign ob_ready_o        = ready_r;
    assign row_done_o        = row_done_r;
    assign done_o            = done_r;
    assign err_overflow_o    = err_r;

endmodule
